sram_fib_ctrl: RTL and testbench
================================

// Module: sram_fib_ctrl
// PURPOSE
//  Initiator side of the single-port SRAM interface (we/oe/address/data_in/data_out).
//  On start, generates Fibonacci terms F(0..count-1) and writes them to SRAM addresses 0..count-1.
//  Then reads them back in address order and streams them out over a valid/ready port.
//  Sits between the top-level control and the sram block; it is the only SRAM master.
// PARAMETERS
//  ADDR_WIDTH  8  SRAM address width; maximum term count is 2**ADDR_WIDTH
//  DATA_WIDTH  8  SRAM data width and Fibonacci term width
// PORTS
//  clk        in   1             system clock; all logic on rising edge
//  rst        in   1             synchronous reset, active-high
//  start      in   1             1-cycle request to begin a run; sampled only in IDLE
//  count      in   ADDR_WIDTH+1  number of terms; latched when start is accepted
//  busy       out  1             high from the cycle after start is accepted until done
//  done       out  1             1-cycle pulse at end of run
//  out_data   out  DATA_WIDTH    term read back from SRAM
//  out_valid  out  1             out_data valid; held until out_ready
//  out_ready  in   1             downstream accepts out_data when out_valid && out_ready
//  overflow   out  1             sticky per run; see CONFIGURATION
//  sram_we    out  1             SRAM write enable, active-high
//  sram_oe    out  1             SRAM output enable, active-high
//  sram_addr  out  ADDR_WIDTH    SRAM address
//  sram_din   out  DATA_WIDTH    SRAM write data
//  sram_dout  in   DATA_WIDTH    SRAM read data; valid the cycle after an oe cycle
// BEHAVIOUR
//  - Reset: state=IDLE; busy, done, out_valid, overflow, sram_we, sram_oe = 0.
//    out_data, sram_addr, sram_din = 0. SRAM contents are not touched.
//  - Reset mid-run: abort immediately to IDLE; no further SRAM access; no done pulse.
//  - FSM: IDLE -> FILL -> RD_REQ -> RD_WAIT -> OUT -> (RD_REQ | FIN) -> IDLE.
//  - IDLE: on start, latch n = min(count, 2**ADDR_WIDTH).
//    - n==0: go to FIN; done pulses the next cycle; zero SRAM accesses.
//    - otherwise: clear overflow, set a=0, b=1, idx=0, and go to FILL.
//  - FILL: each cycle drive sram_we=1, sram_addr=idx, sram_din=a.
//    - Then a<=b, b<=a+b (mod 2**DATA_WIDTH), idx++.
//    - Exactly n consecutive write cycles; after the last one, idx=0 and go to RD_REQ.
//  - RD_REQ: sram_oe=1, sram_we=0, sram_addr=idx for exactly 1 cycle; go to RD_WAIT.
//  - RD_WAIT: capture sram_dout into out_data; out_valid=1 from the next cycle; go to OUT.
//  - OUT: hold out_data and out_valid stable until out_ready.
//    - On handshake: out_valid=0 and idx++.
//    - If idx was n-1, go to FIN; otherwise go to RD_REQ.
//  - Throughput: at most 1 term per 3 cycles while reading.
//  - FIN: done=1 for 1 cycle, busy=0, then return to IDLE.
//  - sram_we and sram_oe are never high in the same cycle; both are 0 outside FILL/RD_REQ.
//  - start while busy is ignored; count changes after acceptance are ignored.
//  - n == 2**ADDR_WIDTH: addresses wrap exactly once, covering 0..2**ADDR_WIDTH-1; no extra access.
// CONFIGURATION
//  - FIB_SATURATE_EN undefined: b<=a+b wraps mod 2**DATA_WIDTH.
//    - overflow goes high (sticky until the next accepted start) on the first carry-out.
//  - FIB_SATURATE_EN defined: b<=a+b clamps to all-ones on carry-out.
//    - overflow is set the same way; once saturated, all later terms read back all-ones.
// TESTING
//  - count=10, out_ready=1 -> 10 writes, data 0,1,1,2,3,5,8,13,21,34 at addresses 0..9;
//    out_data carries the same sequence; one done pulse; overflow=0.
//  - count=0 -> no we/oe cycles; done pulses within 2 cycles of start; busy stays 0.
//  - count=16, wrap build -> F13=233, F14=121, F15=98; overflow=1 after term 14.
//    - With FIB_SATURATE_EN: F14=255, F15=255.
//  - count=4, out_ready low for 5 cycles per term -> out_data/out_valid stable while stalled;
//    exactly 4 handshakes; exactly 4 oe cycles.
//  - Reset asserted on the 3rd FILL cycle -> next cycle we=oe=0, busy=0, no done pulse;
//    a new start with count=3 yields 0,1,1.
//  - start pulsed during OUT with count=5 -> ignored; the original run completes unaltered.

Source files
------------

// File: rtl/sram_fib_ctrl.sv
// Fibonacci fill / read-back controller acting as the sole master of a single-port SRAM.
// Define FIB_SATURATE_EN to clamp terms to all-ones on carry-out instead of wrapping.
module sram_fib_ctrl #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   count,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  overflow,
  output logic                  sram_we,
  output logic                  sram_oe,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_din,
  input  logic [DATA_WIDTH-1:0] sram_dout
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] MAX_N = {1'b1, {ADDR_WIDTH{1'b0}}};

  typedef enum logic [2:0] {IDLE, FILL, RD_REQ, RD_WAIT, OUT, FIN} state_t;

  state_t               state;
  logic [CW-1:0]        n;
  logic [CW-1:0]        idx;
  logic [DATA_WIDTH-1:0] a;
  logic [DATA_WIDTH-1:0] b;

  logic [CW-1:0]         n_sel;
  logic [CW-1:0]         idx_inc;
  logic [DATA_WIDTH:0]   sum_full;
  logic [DATA_WIDTH-1:0] next_b;
  logic                  last;
  logic                  sum_used;

  assign n_sel    = (count > MAX_N) ? MAX_N : count;
  assign idx_inc  = idx + CW'(1);
  assign last     = (idx == n - CW'(1));
  assign sum_full = {1'b0, a} + {1'b0, b};
  // The sum computed at idx is term idx+2; a carry only counts if that term gets written.
  assign sum_used = (idx + CW'(2)) < n;

`ifdef FIB_SATURATE_EN
  assign next_b = sum_full[DATA_WIDTH] ? {DATA_WIDTH{1'b1}} : sum_full[DATA_WIDTH-1:0];
`else
  assign next_b = sum_full[DATA_WIDTH-1:0];
`endif

  // SRAM strobes are registered one step ahead, so sram_din always equals a during FILL.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      n         <= '0;
      idx       <= '0;
      a         <= '0;
      b         <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
      sram_we   <= 1'b0;
      sram_oe   <= 1'b0;
      sram_addr <= '0;
      sram_din  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            n <= n_sel;
            if (n_sel == '0) begin
              done  <= 1'b1;
              state <= FIN;
            end else begin
              overflow  <= 1'b0;
              a         <= '0;
              b         <= {{(DATA_WIDTH-1){1'b0}}, 1'b1};
              idx       <= '0;
              busy      <= 1'b1;
              sram_we   <= 1'b1;
              sram_addr <= '0;
              sram_din  <= '0;
              state     <= FILL;
            end
          end
        end
        FILL: begin
          a <= b;
          b <= next_b;
          if (sum_full[DATA_WIDTH] && sum_used) overflow <= 1'b1;
          if (last) begin
            idx       <= '0;
            sram_we   <= 1'b0;
            sram_oe   <= 1'b1;
            sram_addr <= '0;
            state     <= RD_REQ;
          end else begin
            idx       <= idx_inc;
            sram_addr <= idx_inc[ADDR_WIDTH-1:0];
            sram_din  <= b;
          end
        end
        RD_REQ: begin
          sram_oe <= 1'b0;
          state   <= RD_WAIT;
        end
        RD_WAIT: begin
          out_data  <= sram_dout;
          out_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            idx       <= idx_inc;
            if (last) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= FIN;
            end else begin
              sram_oe   <= 1'b1;
              sram_addr <= idx_inc[ADDR_WIDTH-1:0];
              state     <= RD_REQ;
            end
          end
        end
        FIN: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_fib_ctrl.sv
// Scoreboard bench for sram_fib_ctrl with a behavioural SRAM; expected terms are a hand-computed table.
module tb_sram_fib_ctrl;

  localparam int AW = 8;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW:0]   count;
  logic          busy;
  logic          done;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          overflow;
  logic          sram_we;
  logic          sram_oe;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_din;
  logic [DW-1:0] sram_dout = '0;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [7:0]    fib_tbl [0:15];

  int errors = 0;
  int checks = 0;
  int we_cnt = 0, oe_cnt = 0, hs_cnt = 0, done_cnt = 0, overlap_cnt = 0, busy_cnt = 0;
  int last_we_addr = 0, last_oe_addr = 0;
  int b_we, b_oe, b_hs, b_done, b_ovl, b_busy;
  bit sb_enable = 1'b1;
  bit stall_mode = 1'b0;

  logic [DW-1:0] exp_out_q[$];
  logic [15:0]   exp_wr_q[$];

  always #5 clk = ~clk;

  sram_fib_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .count(count),
    .busy(busy), .done(done), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .overflow(overflow),
    .sram_we(sram_we), .sram_oe(sram_oe), .sram_addr(sram_addr),
    .sram_din(sram_din), .sram_dout(sram_dout)
  );

  always @(posedge clk) begin
    if (sram_we) mem[sram_addr] <= sram_din;
    if (sram_oe) sram_dout <= mem[sram_addr];
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic failNow(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: actual=missing required=present", name);
  endtask

  // Downstream: always ready, or in stall mode hold ready low for 5 cycles of each valid term.
  initial begin
    int wait_cnt = 0;
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      if (!stall_mode) begin
        out_ready = 1'b1;
        wait_cnt = 0;
      end else if (out_valid) begin
        if (wait_cnt == 5) begin
          out_ready = 1'b1;
          wait_cnt = 0;
        end else begin
          out_ready = 1'b0;
          wait_cnt++;
        end
      end else begin
        out_ready = 1'b0;
        wait_cnt = 0;
      end
    end
  end

  // Monitor: pops expected writes and output terms, and checks stability while stalled.
  initial begin
    logic          prev_stalled = 1'b0;
    logic [DW-1:0] prev_data = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stalled = 1'b0;
      end else begin
        if (sram_we && sram_oe) overlap_cnt++;
        if (busy) busy_cnt++;
        if (done) done_cnt++;
        if (sram_oe) begin
          oe_cnt++;
          last_oe_addr = int'(sram_addr);
        end
        if (sram_we) begin
          we_cnt++;
          last_we_addr = int'(sram_addr);
          if (sb_enable) begin
            if (exp_wr_q.size() == 0) failNow("unexpected_write");
            else checkOutput("write_addr_data", {16'h0, sram_addr, sram_din}, {16'h0, exp_wr_q.pop_front()});
          end
        end
        if (prev_stalled) begin
          checkOutput("stall_valid_hold", {31'h0, out_valid}, 32'd1);
          checkOutput("stall_data_hold", {24'h0, out_data}, {24'h0, prev_data});
        end
        if (out_valid && out_ready) begin
          hs_cnt++;
          if (sb_enable) begin
            if (exp_out_q.size() == 0) failNow("unexpected_output");
            else checkOutput("out_data", {24'h0, out_data}, {24'h0, exp_out_q.pop_front()});
          end
        end
        prev_stalled = out_valid && !out_ready;
        prev_data = out_data;
      end
    end
  end

  task automatic snapshot();
    b_we = we_cnt; b_oe = oe_cnt; b_hs = hs_cnt;
    b_done = done_cnt; b_ovl = overlap_cnt; b_busy = busy_cnt;
  endtask

  task automatic applyStimulus(input int cnt, input int n_exp);
    if (sb_enable) begin
      for (int i = 0; i < n_exp; i++) begin
        exp_wr_q.push_back({8'(i), fib_tbl[i]});
        exp_out_q.push_back(fib_tbl[i]);
      end
    end
    @(negedge clk);
    start = 1'b1;
    count = cnt[AW:0];
    @(negedge clk);
    start = 1'b0;
    count = '1;
  endtask

  task automatic waitDone(input string name, output int cycles);
    bit seen = 1'b0;
    cycles = 0;
    for (int i = 0; i < 4000 && !seen; i++) begin
      @(posedge clk);
      #3;
      cycles++;
      if (done_cnt > b_done) seen = 1'b1;
    end
    if (!seen) failNow({name, "_done_timeout"});
  endtask

  task automatic checkRun(input string tag, input int exp_n, input logic exp_ovf);
    repeat (3) @(posedge clk);
    #3;
    checkOutput({tag, "_writes"}, we_cnt - b_we, exp_n);
    checkOutput({tag, "_reads"}, oe_cnt - b_oe, exp_n);
    checkOutput({tag, "_handshakes"}, hs_cnt - b_hs, exp_n);
    checkOutput({tag, "_done_pulses"}, done_cnt - b_done, 1);
    checkOutput({tag, "_we_oe_overlap"}, overlap_cnt - b_ovl, 0);
    checkOutput({tag, "_overflow"}, {31'h0, overflow}, {31'h0, exp_ovf});
    checkOutput({tag, "_busy_end"}, {31'h0, busy}, 32'd0);
    if (sb_enable) checkOutput({tag, "_sb_left"}, exp_out_q.size() + exp_wr_q.size(), 0);
  endtask

  task automatic runTest(input string tag, input int cnt, input int n_exp, input int exp_n,
                         input logic exp_ovf, output int cycles);
    @(posedge clk);
    #3;
    snapshot();
    applyStimulus(cnt, n_exp);
    waitDone(tag, cycles);
    checkRun(tag, exp_n, exp_ovf);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: actual=running required=finished");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cyc;
    bit seen;
`ifdef FIB_SATURATE_EN
    fib_tbl = '{8'd0, 8'd1, 8'd1, 8'd2, 8'd3, 8'd5, 8'd8, 8'd13,
                8'd21, 8'd34, 8'd55, 8'd89, 8'd144, 8'd233, 8'd255, 8'd255};
`else
    fib_tbl = '{8'd0, 8'd1, 8'd1, 8'd2, 8'd3, 8'd5, 8'd8, 8'd13,
                8'd21, 8'd34, 8'd55, 8'd89, 8'd144, 8'd233, 8'd121, 8'd98};
`endif
    rst = 1'b1;
    start = 1'b0;
    count = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_busy", {31'h0, busy}, 32'd0);
    checkOutput("rst_done", {31'h0, done}, 32'd0);
    checkOutput("rst_out_valid", {31'h0, out_valid}, 32'd0);
    checkOutput("rst_overflow", {31'h0, overflow}, 32'd0);
    checkOutput("rst_we", {31'h0, sram_we}, 32'd0);
    checkOutput("rst_oe", {31'h0, sram_oe}, 32'd0);
    checkOutput("rst_out_data", {24'h0, out_data}, 32'd0);
    checkOutput("rst_addr", {24'h0, sram_addr}, 32'd0);
    checkOutput("rst_din", {24'h0, sram_din}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    runTest("fib10", 10, 10, 10, 1'b0, cyc);

    runTest("zero", 0, 0, 0, 1'b0, cyc);
    checkOutput("zero_done_latency_ok", {31'h0, cyc <= 2}, 32'd1);
    checkOutput("zero_busy_cycles", busy_cnt - b_busy, 0);

    runTest("fib16", 16, 16, 16, 1'b1, cyc);

    stall_mode = 1'b1;
    runTest("stall4", 4, 4, 4, 1'b0, cyc);
    stall_mode = 1'b0;

    // Abort during the third write cycle.
    sb_enable = 1'b0;
    @(posedge clk);
    #3;
    snapshot();
    applyStimulus(10, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("abort_we", {31'h0, sram_we}, 32'd0);
    checkOutput("abort_oe", {31'h0, sram_oe}, 32'd0);
    checkOutput("abort_busy", {31'h0, busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #3;
    checkOutput("abort_no_done", done_cnt - b_done, 0);
    checkOutput("abort_no_reads", oe_cnt - b_oe, 0);
    exp_out_q.delete();
    exp_wr_q.delete();
    sb_enable = 1'b1;
    runTest("after_abort", 3, 3, 3, 1'b0, cyc);

    // A second start while streaming must be ignored.
    stall_mode = 1'b1;
    @(posedge clk);
    #3;
    snapshot();
    applyStimulus(5, 5);
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(posedge clk);
      #3;
      if (out_valid) seen = 1'b1;
    end
    if (!seen) failNow("restart_valid_timeout");
    @(negedge clk);
    start = 1'b1;
    count = 9'd3;
    @(negedge clk);
    start = 1'b0;
    waitDone("restart", cyc);
    checkRun("restart", 5, 1'b0);
    stall_mode = 1'b0;

    // Count above the address space clamps to a full single wrap.
    sb_enable = 1'b0;
    runTest("full", 300, 0, 256, 1'b1, cyc);
    checkOutput("full_last_write_addr", last_we_addr, 255);
    checkOutput("full_last_read_addr", last_oe_addr, 255);
    sb_enable = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
